uart_msg_sender: RTL



---
 rtl/uart_msg_sender.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_msg_sender.sv
// -----------------------------------------------------------------------------
// uart_msg_sender
//   Upstream feeder for uart_ctrler. A one-cycle start pulse makes it send the
//   ASCII message "Hello FPGA\r\n" one byte at a time. Each byte is presented
//   on tx_byte, then tx_trigger pulses, and the next byte waits for tx_done.
//
// Optional feature (macro UART_MSG_SENDER_COUNT_EN):
//   The message becomes "Hello FPGA NN\r\n". NN is a decimal message counter
//   (00..99) that advances on every msg_done. It is latched when start is
//   accepted, so it stays constant for the whole message.
//
// Parameters:
//   GAP_CLKS     idle cycles inserted after each tx_done before the next trigger
//   TIMEOUT_CLKS max cycles to wait for tx_done per byte (0 = no timeout)
//
// Ports:
//   sclk         in   system clock
//   nrst         in   asynchronous active-low reset
//   start        in   one-cycle request to send the message
//   tx_done      in   one-cycle pulse from uart_ctrler when a byte is finished
//   tx_trigger   out  one-cycle pulse asking uart_ctrler to send tx_byte
//   tx_byte      out  byte to send; stable from one cycle before tx_trigger
//                     until tx_done
//   busy         out  high from start acceptance until done or abort
//   msg_done     out  one-cycle pulse after the last byte's tx_done
//   tx_err       out  one-cycle pulse when a tx_done timeout aborts the message
//   o_dbg_state  out  current FSM state (IDLE=0, TRIG=1, WAIT=2, GAP=3)
//
// Handshake: tx_byte is loaded one cycle before tx_trigger is raised and is
// held until tx_done is seen; tx_done is only acted on in WAIT, so a tx_done
// arriving at any other time is ignored.
// -----------------------------------------------------------------------------
module uart_msg_sender #(
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic       start,
    input  logic       tx_done,
    output logic       tx_trigger,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       msg_done,
    output logic       tx_err,
    output logic [1:0] o_dbg_state
);

`ifdef UART_MSG_SENDER_COUNT_EN
    localparam int MSG_LEN = 15;
    localparam int IDX_W   = 5;
`else
    localparam int MSG_LEN = 12;
    localparam int IDX_W   = 4;
`endif

    // A zero gap still needs a legal 1-bit counter, and the timeout counter
    // is at least 17 bits wide.
    localparam int GAP_W  = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam int TO_CLG = $clog2(TIMEOUT_CLKS + 1);
    localparam int TO_W   = (TO_CLG > 17) ? TO_CLG : 17;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRIG = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [IDX_W-1:0] w_next_idx;

`ifdef UART_MSG_SENDER_COUNT_EN
    logic [3:0] r_cnt_t;   // running message counter, tens digit
    logic [3:0] r_cnt_o;   // running message counter, ones digit
    logic [3:0] r_dig_t;   // digits frozen for the message in flight
    logic [3:0] r_dig_o;
`endif

    assign w_next_idx  = r_idx + 1'b1;
    assign o_dbg_state = r_state;

    // Combinational message ROM.
    function automatic logic [7:0] f_rom(input logic [IDX_W-1:0] i);
        logic [7:0] b;
        case (i)
            IDX_W'(0):  b = 8'h48;
            IDX_W'(1):  b = 8'h65;
            IDX_W'(2):  b = 8'h6C;
            IDX_W'(3):  b = 8'h6C;
            IDX_W'(4):  b = 8'h6F;
            IDX_W'(5):  b = 8'h20;
            IDX_W'(6):  b = 8'h46;
            IDX_W'(7):  b = 8'h50;
            IDX_W'(8):  b = 8'h47;
            IDX_W'(9):  b = 8'h41;
`ifdef UART_MSG_SENDER_COUNT_EN
            IDX_W'(10): b = 8'h20;
            IDX_W'(11): b = {4'h3, r_dig_t};
            IDX_W'(12): b = {4'h3, r_dig_o};
            IDX_W'(13): b = 8'h0D;
            IDX_W'(14): b = 8'h0A;
`else
            IDX_W'(10): b = 8'h0D;
            IDX_W'(11): b = 8'h0A;
`endif
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
            tx_trigger <= 1'b0;
            tx_byte    <= 8'h00;
            busy       <= 1'b0;
            msg_done   <= 1'b0;
            tx_err     <= 1'b0;
`ifdef UART_MSG_SENDER_COUNT_EN
            r_cnt_t    <= 4'd0;
            r_cnt_o    <= 4'd0;
            r_dig_t    <= 4'd0;
            r_dig_o    <= 4'd0;
`endif
        end else begin
            // Pulse outputs default low; each is raised for a single cycle.
            tx_trigger <= 1'b0;
            msg_done   <= 1'b0;
            tx_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        tx_byte <= f_rom('0);
                        busy    <= 1'b1;
                        r_state <= S_TRIG;
`ifdef UART_MSG_SENDER_COUNT_EN
                        r_dig_t <= r_cnt_t;
                        r_dig_o <= r_cnt_o;
`endif
                    end
                end
                S_TRIG: begin
                    tx_trigger <= 1'b1;
                    r_to_cnt   <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    // tx_done is tested first so it wins over a same-cycle timeout.
                    if (tx_done) begin
                        if (r_idx == IDX_LAST) begin
                            busy     <= 1'b0;
                            msg_done <= 1'b1;
                            r_idx    <= '0;
                            r_state  <= S_IDLE;
`ifdef UART_MSG_SENDER_COUNT_EN
                            if (r_cnt_o == 4'd9) begin
                                r_cnt_o <= 4'd0;
                                r_cnt_t <= (r_cnt_t == 4'd9) ? 4'd0 : r_cnt_t + 4'd1;
                            end else begin
                                r_cnt_o <= r_cnt_o + 4'd1;
                            end
`endif
                        end else begin
                            r_idx   <= w_next_idx;
                            tx_byte <= f_rom(w_next_idx);
                            if (GAP_CLKS > 0) begin
                                r_gap_cnt <= '0;
                                r_state   <= S_GAP;
                            end else begin
                                r_state <= S_TRIG;
                            end
                        end
                    end else if ((TIMEOUT_CLKS != 0) && (r_to_cnt == TO_LAST)) begin
                        // Abort; tx_byte keeps the byte that never completed.
                        tx_err  <= 1'b1;
                        busy    <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_TRIG;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
